// File: rtl/line_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : line_read_scheduler
// Description : Issues one DDR2 line-read request per display line. The line
//               address is tracked incrementally, the two line buffers are
//               ping-ponged and the frame base is double-buffered.
//               Optional macro LINE_SCHED_STATS_EN adds the overrun_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
module line_read_scheduler #(
    parameter int unsigned LINE_BYTES    = 2560,
    parameter int unsigned V_IMG_RES     = 480,
    parameter int unsigned FRAME_BASE_0  = 0,
    parameter int unsigned FRAME_BASE_1  = 1228800,
    parameter int unsigned START_TIMEOUT = 64
) (
    input  logic        app_clk,
    input  logic        rst_n,
    input  logic        mem_calib_done,
    input  logic        vid_preload_line,
    input  logic [10:0] vid_vpos,
    input  logic        frame_written,
    input  logic        rd_busy,
    output logic        os_start_rd,
    output logic [29:0] init_add_rd,
    output logic        line_buf_sel,
    output logic        line_blank,
    output logic        frame_sel
`ifdef LINE_SCHED_STATS_EN
    ,
    output logic [15:0] overrun_cnt
`endif
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_ISSUE     = 2'd1;
    localparam logic [1:0] c_WAIT_DONE = 2'd2;
    localparam logic [1:0] c_DESYNC    = 2'd3;

    localparam int unsigned c_TMO_W    = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam int unsigned c_TMO_M1   = START_TIMEOUT - 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_M1[c_TMO_W-1:0];
    localparam logic [29:0] c_BASE_0   = FRAME_BASE_0[29:0];
    localparam logic [29:0] c_BASE_1   = FRAME_BASE_1[29:0];
    localparam logic [29:0] c_LINE     = LINE_BYTES[29:0];

    logic [1:0]         r_state,     w_state;
    logic               r_os_start,  w_os_start;
    logic [29:0]        r_init_add,  w_init_add;
    logic               r_buf_sel,   w_buf_sel;
    logic               r_blank,     w_blank;
    logic               r_frame_sel, w_frame_sel;
    logic               r_swap_pend, w_swap_pend;
    logic [10:0]        r_exp_vpos,  w_exp_vpos;
    logic [29:0]        r_next_addr, w_next_addr;
    logic               r_lost,      w_lost;
    logic               r_calib_q;
    logic [c_TMO_W-1:0] r_tmo,       w_tmo;

    logic        w_overrun;
    logic        w_return;
    logic        w_frame_start;
    logic        w_in_seq;
    logic        w_in_img;
    logic        w_busy_state;
    logic        w_calib_fall;
    logic [29:0] w_line_addr;

    assign w_frame_start = vid_preload_line && (vid_vpos == 11'd0);
    assign w_in_seq      = vid_preload_line && (vid_vpos != 11'd0) && (vid_vpos == r_exp_vpos)
                           && (r_state != c_DESYNC) && !r_lost;
    assign w_in_img      = (32'(vid_vpos) < V_IMG_RES);
    assign w_busy_state  = (r_state == c_ISSUE) || (r_state == c_WAIT_DONE);
    assign w_calib_fall  = r_calib_q && !mem_calib_done;

    always_comb begin
        w_state     = r_state;
        w_os_start  = r_os_start;
        w_init_add  = r_init_add;
        w_buf_sel   = r_buf_sel;
        w_blank     = r_blank;
        w_frame_sel = r_frame_sel;
        w_swap_pend = r_swap_pend | frame_written;
        w_exp_vpos  = r_exp_vpos;
        w_next_addr = r_next_addr;
        w_lost      = r_lost;
        w_tmo       = r_tmo;
        w_overrun   = 1'b0;
        w_return    = 1'b0;
        w_line_addr = r_next_addr;

        case (r_state)
            c_ISSUE: begin
                if (rd_busy) begin
                    w_os_start = 1'b0;
                    w_state    = c_WAIT_DONE;
                end else if (r_tmo == c_TMO_LAST) begin
                    w_os_start = 1'b0;
                    w_blank    = 1'b1;
                    w_overrun  = 1'b1;
                    w_return   = 1'b1;
                end else begin
                    w_tmo = r_tmo + 1'b1;
                end
            end
            c_WAIT_DONE: begin
                if (!rd_busy) begin
                    w_buf_sel = ~r_buf_sel;
                    w_return  = 1'b1;
                end
            end
            default: ;
        endcase

        if (vid_preload_line) begin
            w_blank = 1'b1;
            if (w_frame_start) begin
                // A swap requested in this very cycle still applies to this frame
                w_frame_sel = r_frame_sel ^ (r_swap_pend | frame_written);
                w_swap_pend = 1'b0;
                w_line_addr = w_frame_sel ? c_BASE_1 : c_BASE_0;
                w_exp_vpos  = 11'd1;
                w_next_addr = w_line_addr + c_LINE;
                w_lost      = 1'b0;
            end else if (w_in_seq) begin
                w_exp_vpos  = r_exp_vpos + 11'd1;
                w_next_addr = r_next_addr + c_LINE;
            end else if (w_busy_state) begin
                // Transfer in flight: finish it, then sit in DESYNC
                w_lost = 1'b1;
            end else begin
                w_state = c_DESYNC;
            end

            if (w_busy_state) begin
                w_overrun = 1'b1;
            end else if ((w_frame_start || w_in_seq) && mem_calib_done && w_in_img) begin
                w_state    = c_ISSUE;
                w_os_start = 1'b1;
                w_init_add = w_line_addr;
                w_blank    = 1'b0;
                w_tmo      = '0;
            end else if (w_frame_start) begin
                w_state = c_IDLE;
            end
        end

        if (w_calib_fall) begin
            w_os_start = 1'b0;
            w_blank    = 1'b1;
            if ((w_state == c_ISSUE) || (w_state == c_WAIT_DONE)) begin
                w_return = 1'b1;
            end
        end

        if (w_return) begin
            w_state = w_lost ? c_DESYNC : c_IDLE;
        end
    end

    always_ff @(posedge app_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_os_start  <= 1'b0;
            r_init_add  <= '0;
            r_buf_sel   <= 1'b0;
            r_blank     <= 1'b1;
            r_frame_sel <= 1'b0;
            r_swap_pend <= 1'b0;
            r_exp_vpos  <= '0;
            r_next_addr <= c_BASE_0;
            r_lost      <= 1'b0;
            r_calib_q   <= 1'b0;
            r_tmo       <= '0;
        end else begin
            r_state     <= w_state;
            r_os_start  <= w_os_start;
            r_init_add  <= w_init_add;
            r_buf_sel   <= w_buf_sel;
            r_blank     <= w_blank;
            r_frame_sel <= w_frame_sel;
            r_swap_pend <= w_swap_pend;
            r_exp_vpos  <= w_exp_vpos;
            r_next_addr <= w_next_addr;
            r_lost      <= w_lost;
            r_calib_q   <= mem_calib_done;
            r_tmo       <= w_tmo;
        end
    end

`ifdef LINE_SCHED_STATS_EN
    logic [15:0] r_ovr_cnt;

    always_ff @(posedge app_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr_cnt <= '0;
        end else if (w_overrun && (r_ovr_cnt != 16'hFFFF)) begin
            r_ovr_cnt <= r_ovr_cnt + 16'd1;
        end
    end

    assign overrun_cnt = r_ovr_cnt;
`else
    logic w_unused_overrun;
    assign w_unused_overrun = w_overrun;
`endif

    assign os_start_rd  = r_os_start;
    assign init_add_rd  = r_init_add;
    assign line_buf_sel = r_buf_sel;
    assign line_blank   = r_blank;
    assign frame_sel    = r_frame_sel;

endmodule
`default_nettype wire

// File: tb/tb_line_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_read_scheduler
// Description : Self-checking bench: cycle vector table plus directed
//               sequences for timeout, image bottom edge and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_read_scheduler;

    logic        app_clk;
    logic        rst_n;
    logic        mem_calib_done;
    logic        vid_preload_line;
    logic [10:0] vid_vpos;
    logic        frame_written;
    logic        rd_busy;
    logic        os_start_rd;
    logic [29:0] init_add_rd;
    logic        line_buf_sel;
    logic        line_blank;
    logic        frame_sel;
`ifdef LINE_SCHED_STATS_EN
    logic [15:0] overrun_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    line_read_scheduler dut (
        .app_clk          (app_clk),
        .rst_n            (rst_n),
        .mem_calib_done   (mem_calib_done),
        .vid_preload_line (vid_preload_line),
        .vid_vpos         (vid_vpos),
        .frame_written    (frame_written),
        .rd_busy          (rd_busy),
        .os_start_rd      (os_start_rd),
        .init_add_rd      (init_add_rd),
        .line_buf_sel     (line_buf_sel),
        .line_blank       (line_blank),
        .frame_sel        (frame_sel)
`ifdef LINE_SCHED_STATS_EN
        ,
        .overrun_cnt      (overrun_cnt)
`endif
    );

    initial app_clk = 1'b0;
    always #5 app_clk = ~app_clk;

    typedef struct {
        logic        pre;
        logic [10:0] vpos;
        logic        cal;
        logic        fw;
        logic        busy;
        logic        os;
        logic [29:0] addr;
        logic        sel;
        logic        blank;
        logic        fs;
        logic [15:0] ovr;
    } vec_t;

    localparam int c_NVEC = 36;
    vec_t vt [c_NVEC];

    function automatic vec_t mk(input logic pre, input int vpos, input logic cal,
                                input logic fw, input logic busy, input logic os,
                                input int addr, input logic sel, input logic blank,
                                input logic fs, input int ovr);
        vec_t v;
        v.pre = pre;  v.vpos = 11'(vpos); v.cal = cal; v.fw = fw; v.busy = busy;
        v.os = os;    v.addr = 30'(addr); v.sel = sel; v.blank = blank; v.fs = fs;
        v.ovr = 16'(ovr);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge app_clk);
        #1;
    endtask

    task automatic preload(input int vpos);
        vid_preload_line = 1'b1;
        vid_vpos         = 11'(vpos);
        tick();
        vid_preload_line = 1'b0;
        vid_vpos         = '0;
    endtask

    task automatic ack();
        rd_busy = 1'b1;
        tick();
        rd_busy = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        // pre vpos cal fw busy | os addr sel blank fs ovr
        vt[0]  = mk(1, 0, 1, 0, 0,  1, 0,       0, 0, 0, 0);
        vt[1]  = mk(0, 0, 1, 0, 0,  1, 0,       0, 0, 0, 0);
        vt[2]  = mk(0, 0, 1, 0, 1,  0, 0,       0, 0, 0, 0);
        vt[3]  = mk(0, 0, 1, 0, 1,  0, 0,       0, 0, 0, 0);
        vt[4]  = mk(0, 0, 1, 0, 0,  0, 0,       1, 0, 0, 0);
        vt[5]  = mk(1, 1, 1, 0, 0,  1, 2560,    1, 0, 0, 0);
        vt[6]  = mk(0, 0, 1, 0, 1,  0, 2560,    1, 0, 0, 0);
        vt[7]  = mk(0, 0, 1, 0, 0,  0, 2560,    0, 0, 0, 0);
        vt[8]  = mk(1, 2, 1, 0, 0,  1, 5120,    0, 0, 0, 0);
        vt[9]  = mk(0, 0, 1, 0, 1,  0, 5120,    0, 0, 0, 0);
        vt[10] = mk(0, 0, 1, 0, 0,  0, 5120,    1, 0, 0, 0);
        vt[11] = mk(1, 3, 1, 0, 0,  1, 7680,    1, 0, 0, 0);
        vt[12] = mk(0, 0, 1, 0, 1,  0, 7680,    1, 0, 0, 0);
        vt[13] = mk(1, 4, 1, 0, 1,  0, 7680,    1, 1, 0, 1);  // overrun
        vt[14] = mk(0, 0, 1, 0, 0,  0, 7680,    0, 1, 0, 1);
        vt[15] = mk(1, 5, 1, 0, 0,  1, 12800,   0, 0, 0, 1);  // skipped line still advanced
        vt[16] = mk(0, 0, 1, 0, 1,  0, 12800,   0, 0, 0, 1);
        vt[17] = mk(0, 0, 1, 0, 0,  0, 12800,   1, 0, 0, 1);
        vt[18] = mk(0, 0, 0, 0, 0,  0, 12800,   1, 1, 0, 1);  // calib falls
        vt[19] = mk(1, 6, 0, 0, 0,  0, 12800,   1, 1, 0, 1);
        vt[20] = mk(1, 7, 1, 0, 0,  1, 17920,   1, 0, 0, 1);
        vt[21] = mk(0, 0, 1, 0, 1,  0, 17920,   1, 0, 0, 1);
        vt[22] = mk(0, 0, 1, 0, 0,  0, 17920,   0, 0, 0, 1);
        vt[23] = mk(1, 9, 1, 0, 0,  0, 17920,   0, 1, 0, 1);  // desync
        vt[24] = mk(1, 8, 1, 0, 0,  0, 17920,   0, 1, 0, 1);
        vt[25] = mk(0, 0, 1, 1, 0,  0, 17920,   0, 1, 0, 1);
        vt[26] = mk(0, 0, 1, 1, 0,  0, 17920,   0, 1, 0, 1);
        vt[27] = mk(1, 0, 1, 0, 0,  1, 1228800, 0, 0, 1, 1);  // single swap
        vt[28] = mk(0, 0, 1, 0, 1,  0, 1228800, 0, 0, 1, 1);
        vt[29] = mk(0, 0, 1, 0, 0,  0, 1228800, 1, 0, 1, 1);
        vt[30] = mk(1, 1, 1, 0, 0,  1, 1231360, 1, 0, 1, 1);
        vt[31] = mk(0, 0, 1, 0, 1,  0, 1231360, 1, 0, 1, 1);
        vt[32] = mk(0, 0, 1, 0, 0,  0, 1231360, 0, 0, 1, 1);
        vt[33] = mk(1, 0, 1, 1, 0,  1, 0,       0, 0, 0, 1);  // simultaneous swap
        vt[34] = mk(0, 0, 1, 0, 1,  0, 0,       0, 0, 0, 1);
        vt[35] = mk(0, 0, 1, 0, 0,  0, 0,       1, 0, 0, 1);

        rst_n = 1'b0; mem_calib_done = 1'b1; vid_preload_line = 1'b0;
        vid_vpos = '0; frame_written = 1'b0; rd_busy = 1'b0;
        tick(); tick();
        chk("reset os_start_rd",  32'(os_start_rd),  0);
        chk("reset init_add_rd",  32'(init_add_rd),  0);
        chk("reset line_buf_sel", 32'(line_buf_sel), 0);
        chk("reset line_blank",   32'(line_blank),   1);
        chk("reset frame_sel",    32'(frame_sel),    0);
`ifdef LINE_SCHED_STATS_EN
        chk("reset overrun_cnt",  32'(overrun_cnt),  0);
`endif
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < c_NVEC; i++) begin
            vid_preload_line = vt[i].pre;
            vid_vpos         = vt[i].vpos;
            mem_calib_done   = vt[i].cal;
            frame_written    = vt[i].fw;
            rd_busy          = vt[i].busy;
            tick();
            chk($sformatf("row%0d os_start_rd", i),  32'(os_start_rd),  32'(vt[i].os));
            chk($sformatf("row%0d init_add_rd", i),  32'(init_add_rd),  32'(vt[i].addr));
            chk($sformatf("row%0d line_buf_sel", i), 32'(line_buf_sel), 32'(vt[i].sel));
            chk($sformatf("row%0d line_blank", i),   32'(line_blank),   32'(vt[i].blank));
            chk($sformatf("row%0d frame_sel", i),    32'(frame_sel),    32'(vt[i].fs));
`ifdef LINE_SCHED_STATS_EN
            chk($sformatf("row%0d overrun_cnt", i),  32'(overrun_cnt),  32'(vt[i].ovr));
`endif
        end
        vid_preload_line = 1'b0; frame_written = 1'b0; rd_busy = 1'b0; mem_calib_done = 1'b1;

        // Start timeout: rd_busy never rises
        preload(1);
        chk("timeout first addr", 32'(init_add_rd), 2560);
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            if (!os_start_rd) break;
            cnt++;
            tick();
        end
        chk("timeout os_start_rd high cycles", 32'(cnt), 64);
        chk("timeout line_blank", 32'(line_blank), 1);
`ifdef LINE_SCHED_STATS_EN
        chk("timeout overrun_cnt", 32'(overrun_cnt), 2);
`endif
        preload(2);
        chk("after timeout issue", {1'b0, os_start_rd, init_add_rd}, {2'b01, 30'd5120});
        ack();

        // A full frame up to the image bottom edge
        for (int k = 0; k < 480; k++) begin
            preload(k);
            chk($sformatf("frame line %0d", k), {1'b0, os_start_rd, init_add_rd},
                {2'b01, 30'(k * 2560)});
            ack();
        end
        preload(480);
        chk("vpos 480 os_start_rd", 32'(os_start_rd), 0);
        chk("vpos 480 line_blank",  32'(line_blank),  1);

        // Asynchronous reset while waiting for the burst to finish
        frame_written = 1'b1;
        tick();
        frame_written = 1'b0;
        preload(0);
        chk("pre-reset addr", 32'(init_add_rd), 1228800);
        chk("pre-reset frame_sel", 32'(frame_sel), 1);
        rd_busy = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset os_start_rd", 32'(os_start_rd), 0);
        chk("async reset init_add_rd", 32'(init_add_rd), 0);
        chk("async reset line_buf_sel", 32'(line_buf_sel), 0);
        chk("async reset line_blank",  32'(line_blank),  1);
        chk("async reset frame_sel",   32'(frame_sel),   0);
`ifdef LINE_SCHED_STATS_EN
        chk("async reset overrun_cnt", 32'(overrun_cnt), 0);
`endif
        rd_busy = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
